// File: rtl/sweep_pkg.sv
// Shared types for the sweep checker: FSM encoding, golden op codes and the
// stage-1 vector payload.
package sweep_pkg;

  localparam int unsigned DATA_W = 4;
  localparam int unsigned CNT_W  = 9;
  localparam int unsigned PAIRS  = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_XOR = 2'd3
  } op_t;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] o;
    op_t               op;
  } vec_t;

endpackage

// File: rtl/golden_alu.sv
// Reference model of the design under check; 4-bit results, carry/borrow dropped.
module golden_alu
  import sweep_pkg::*;
(
  input  op_t               op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] expected_c
);

  always_comb begin
    expected_c = '0;
    case (op)
      OP_ADD: expected_c = a + b;
      OP_SUB: expected_c = a - b;
      OP_AND: expected_c = a & b;
      OP_XOR: expected_c = a ^ b;
    endcase
  end

endmodule

// File: rtl/sweep_checker.sv
// Two-stage checker: stage 1 registers an observed vector, stage 2 compares it
// against golden_alu and updates counters, coverage and first-fail capture.
module sweep_checker
  import sweep_pkg::*;
#(
  parameter int unsigned IDLE_LIMIT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              valid,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] o,
  input  logic [1:0]        op,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic              fail_seen,
  output logic [11:0]       first_fail,
  output logic              done,
  output logic              timeout
);

  localparam int unsigned IDLE_W = $clog2(IDLE_LIMIT + 1);

  state_t            state, state_next;
  logic [IDLE_W-1:0] idle_cnt, idle_next;
  logic              timeout_next;
  logic              accept_c;

  vec_t              s1;
  logic              s1_valid;
  logic [DATA_W-1:0] expected_c;
  logic              match_c;
  logic              new_pair_c;
  logic              cov_full_c;
  logic [PAIRS-1:0]  cov_map;
  logic [CNT_W-1:0]  cov_cnt;

  golden_alu u_golden (
    .op         (s1.op),
    .a          (s1.a),
    .b          (s1.b),
    .expected_c (expected_c)
  );

  assign match_c    = (expected_c == s1.o);
  assign new_pair_c = s1_valid && !cov_map[{s1.a, s1.b}];
  // The stage-2 vector completes the map: DONE is entered on this same edge.
  assign cov_full_c = new_pair_c && (cov_cnt == CNT_W'(PAIRS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idle_cnt <= '0;
      timeout  <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_next;
      idle_cnt <= idle_next;
      timeout  <= timeout_next;
      done     <= (state_next == DONE);
    end
  end

  always_comb begin
    state_next   = state;
    idle_next    = idle_cnt;
    timeout_next = timeout;
    accept_c     = 1'b0;
    case (state)
      IDLE: begin
        if (valid) begin
          accept_c   = 1'b1;
          idle_next  = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        if (valid) begin
          accept_c  = 1'b1;
          idle_next = '0;
        end else if (idle_cnt == IDLE_W'(IDLE_LIMIT - 1)) begin
          idle_next    = IDLE_W'(IDLE_LIMIT);
          state_next   = DONE;
          timeout_next = 1'b1;
        end else begin
          idle_next = idle_cnt + IDLE_W'(1);
        end
        if (cov_full_c) begin
          state_next   = DONE;
          timeout_next = timeout;
        end
      end
      default: ;
    endcase
    // clear wins over everything, including a coincident valid
    if (clear) begin
      state_next   = IDLE;
      idle_next    = '0;
      timeout_next = 1'b0;
      accept_c     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1         <= '0;
      cov_map    <= '0;
      cov_cnt    <= '0;
      pass_cnt   <= '0;
      fail_cnt   <= '0;
      fail_seen  <= 1'b0;
      first_fail <= '0;
    end else if (clear) begin
      s1_valid   <= 1'b0;
      s1         <= '0;
      cov_map    <= '0;
      cov_cnt    <= '0;
      pass_cnt   <= '0;
      fail_cnt   <= '0;
      fail_seen  <= 1'b0;
      first_fail <= '0;
    end else begin
      s1_valid <= accept_c;
      if (accept_c) s1 <= '{a: a, b: b, o: o, op: op_t'(op)};
      if (s1_valid) begin
        cov_map[{s1.a, s1.b}] <= 1'b1;
        if (new_pair_c) cov_cnt <= cov_cnt + CNT_W'(1);
        if (match_c) begin
          if (pass_cnt != '1) pass_cnt <= pass_cnt + CNT_W'(1);
        end else begin
          if (fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
          if (!fail_seen) begin
            fail_seen  <= 1'b1;
            first_fail <= {s1.a, s1.b, s1.o};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sweep_checker.sv
// Directed bench for sweep_checker (IDLE_LIMIT=16): sweep, fault capture,
// timeout, saturation, clear collision and asynchronous reset.
module tb_sweep_checker;

  logic       clk = 1'b0;
  logic       rst, clear, valid;
  logic [3:0] a, b, o;
  logic [1:0] op;
  logic [8:0] pass_cnt, fail_cnt;
  logic       fail_seen, done, timeout;
  logic [11:0] first_fail;

  int compared = 0;
  int errors   = 0;

  sweep_checker #(.IDLE_LIMIT(16)) dut (
    .clk(clk), .rst(rst), .clear(clear), .valid(valid),
    .a(a), .b(b), .o(o), .op(op),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .fail_seen(fail_seen),
    .first_fail(first_fail), .done(done), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] p, input logic [3:0] va,
                       input logic [3:0] vb, input logic [3:0] vo);
    valid = v; op = p; a = va; b = vb; o = vo;
    step();
  endtask

  task automatic do_clear();
    valid = 1'b0; clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; valid = 1'b0; a = '0; b = '0; o = '0; op = '0;
    step();
    compared++; if (pass_cnt !== 9'd0) begin errors++; $display("FAIL reset_pass got %0d want 0", pass_cnt); end
    compared++; if (fail_cnt !== 9'd0) begin errors++; $display("FAIL reset_fail got %0d want 0", fail_cnt); end
    compared++; if ({fail_seen, done, timeout} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {fail_seen, done, timeout}); end
    compared++; if (first_fail !== 12'h000) begin errors++; $display("FAIL reset_first got %h want 000", first_fail); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_sweep();
    do_clear();
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        drive(1'b1, 2'd0, 4'(i), 4'(j), 4'((i + j) % 16));
    valid = 1'b0;
    compared++; if (pass_cnt !== 9'd255 || done !== 1'b0) begin errors++; $display("FAIL sweep_t1 got pass=%0d done=%b want 255 0", pass_cnt, done); end
    step();
    compared++; if (pass_cnt !== 9'd256) begin errors++; $display("FAIL sweep_pass got %0d want 256", pass_cnt); end
    compared++; if (fail_cnt !== 9'd0 || fail_seen !== 1'b0) begin errors++; $display("FAIL sweep_fail got %0d/%b want 0/0", fail_cnt, fail_seen); end
    compared++; if (done !== 1'b1 || timeout !== 1'b0) begin errors++; $display("FAIL sweep_done got done=%b timeout=%b want 1 0", done, timeout); end
    // a vector presented in DONE must be ignored
    drive(1'b1, 2'd0, 4'd1, 4'd1, 4'd7);
    valid = 1'b0;
    step(); step();
    compared++; if (pass_cnt !== 9'd256 || fail_cnt !== 9'd0 || done !== 1'b1) begin errors++; $display("FAIL done_ignore got pass=%0d fail=%0d done=%b want 256 0 1", pass_cnt, fail_cnt, done); end
  endtask

  task automatic test_single_fault();
    do_clear();
    compared++; if (done !== 1'b0 || pass_cnt !== 9'd0) begin errors++; $display("FAIL clear_done got done=%b pass=%0d want 0 0", done, pass_cnt); end
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        drive(1'b1, 2'd3, 4'(i), 4'(j), (i == 5 && j == 9) ? 4'd0 : 4'(i ^ j));
    valid = 1'b0;
    step();
    compared++; if (pass_cnt !== 9'd255 || fail_cnt !== 9'd1) begin errors++; $display("FAIL fault_cnt got %0d/%0d want 255/1", pass_cnt, fail_cnt); end
    compared++; if (first_fail !== 12'h590 || fail_seen !== 1'b1) begin errors++; $display("FAIL fault_first got %h/%b want 590/1", first_fail, fail_seen); end
    compared++; if (done !== 1'b1) begin errors++; $display("FAIL fault_done got %b want 1", done); end
  endtask

  task automatic test_ops();
    do_clear();
    drive(1'b1, 2'd0, 4'd15, 4'd1, 4'd0);
    compared++; if (pass_cnt !== 9'd0) begin errors++; $display("FAIL latency_early got %0d want 0", pass_cnt); end
    drive(1'b1, 2'd1, 4'd3, 4'd5, 4'd14);
    compared++; if (pass_cnt !== 9'd1) begin errors++; $display("FAIL latency_two got %0d want 1", pass_cnt); end
    drive(1'b1, 2'd1, 4'd0, 4'd1, 4'd15);
    drive(1'b1, 2'd2, 4'd12, 4'd10, 4'd8);
    drive(1'b1, 2'd2, 4'd15, 4'd15, 4'd14);
    drive(1'b1, 2'd3, 4'd6, 4'd3, 4'd5);
    drive(1'b1, 2'd1, 4'd2, 4'd1, 4'd3);
    valid = 1'b0;
    step(); step();
    compared++; if (pass_cnt !== 9'd5 || fail_cnt !== 9'd2) begin errors++; $display("FAIL ops_cnt got %0d/%0d want 5/2", pass_cnt, fail_cnt); end
    compared++; if (first_fail !== 12'hffe || fail_seen !== 1'b1) begin errors++; $display("FAIL ops_first got %h/%b want ffe/1", first_fail, fail_seen); end
    compared++; if (done !== 1'b0) begin errors++; $display("FAIL ops_done got %b want 0", done); end
  endtask

  task automatic test_timeout();
    do_clear();
    for (int i = 0; i < 10; i++) drive(1'b1, 2'd0, 4'(i), 4'd0, 4'(i));
    valid = 1'b0;
    for (int i = 0; i < 15; i++) step();
    compared++; if (done !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL timeout_early got %b/%b want 0/0", done, timeout); end
    step();
    compared++; if (done !== 1'b1 || timeout !== 1'b1) begin errors++; $display("FAIL timeout_hit got %b/%b want 1/1", done, timeout); end
    compared++; if (pass_cnt !== 9'd10 || fail_cnt !== 9'd0) begin errors++; $display("FAIL timeout_cnt got %0d/%0d want 10/0", pass_cnt, fail_cnt); end
    do_clear();
    compared++; if (done !== 1'b0 || timeout !== 1'b0 || pass_cnt !== 9'd0) begin errors++; $display("FAIL timeout_clear got %b/%b/%0d want 0/0/0", done, timeout, pass_cnt); end
  endtask

  task automatic test_saturation();
    do_clear();
    for (int i = 0; i < 600; i++) drive(1'b1, 2'd0, 4'd1, 4'd1, 4'd2);
    valid = 1'b0;
    step(); step();
    compared++; if (pass_cnt !== 9'd511 || fail_cnt !== 9'd0) begin errors++; $display("FAIL sat_cnt got %0d/%0d want 511/0", pass_cnt, fail_cnt); end
    compared++; if (done !== 1'b0) begin errors++; $display("FAIL sat_done got %b want 0", done); end
  endtask

  task automatic test_clear_collision();
    do_clear();
    drive(1'b1, 2'd0, 4'd2, 4'd3, 4'd5);
    drive(1'b1, 2'd0, 4'd2, 4'd4, 4'd0);
    drive(1'b1, 2'd0, 4'd2, 4'd5, 4'd7);
    compared++; if (pass_cnt !== 9'd1 || fail_seen !== 1'b1 || first_fail !== 12'h240) begin errors++; $display("FAIL coll_pre got %0d/%b/%h want 1/1/240", pass_cnt, fail_seen, first_fail); end
    clear = 1'b1;
    drive(1'b1, 2'd0, 4'd7, 4'd7, 4'd14);
    clear = 1'b0; valid = 1'b0;
    compared++; if (pass_cnt !== 9'd0 || fail_cnt !== 9'd0 || fail_seen !== 1'b0 || first_fail !== 12'h000 || done !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL coll_zero got %0d/%0d/%b/%h/%b/%b want all 0", pass_cnt, fail_cnt, fail_seen, first_fail, done, timeout); end
    // IDLE has no idle limit, so staying quiet here must not time out
    for (int i = 0; i < 20; i++) step();
    compared++; if (pass_cnt !== 9'd0 || done !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL coll_idle got %0d/%b/%b want 0/0/0", pass_cnt, done, timeout); end
  endtask

  task automatic test_async_reset();
    do_clear();
    drive(1'b1, 2'd0, 4'd3, 4'd3, 4'd6);
    drive(1'b1, 2'd0, 4'd3, 4'd4, 4'd1);
    valid = 1'b0;
    compared++; if (pass_cnt !== 9'd1) begin errors++; $display("FAIL arst_pre got %0d want 1", pass_cnt); end
    #2 rst = 1'b1;
    #1;
    compared++; if (pass_cnt !== 9'd0 || fail_cnt !== 9'd0 || done !== 1'b0) begin errors++; $display("FAIL arst_now got %0d/%0d/%b want 0/0/0", pass_cnt, fail_cnt, done); end
    #2 rst = 1'b0;
    step(); step();
    compared++; if (pass_cnt !== 9'd0 || fail_cnt !== 9'd0 || fail_seen !== 1'b0) begin errors++; $display("FAIL arst_after got %0d/%0d/%b want 0/0/0", pass_cnt, fail_cnt, fail_seen); end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_single_fault();
    test_ops();
    test_timeout();
    test_saturation();
    test_clear_collision();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, errors);
    $finish;
  end

endmodule
